// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand-mux selects,
// memory-wait FSM states and the retired-write buffer entry.
package hazard_pkg;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;
  localparam logic [1:0] SEL_RET = 2'd3;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wait_state_t;

  // The entry is sized for the widest supported configuration (REG_AW <= 16,
  // DATA_W <= 64); narrower instances zero-extend into it.
  localparam int RET_AW_MAX = 16;
  localparam int RET_DW_MAX = 64;

  typedef struct packed {
    logic                  valid;
    logic [RET_AW_MAX-1:0] dest;
    logic [RET_DW_MAX-1:0] data;
  } ret_entry_t;

endpackage

// File: rtl/src_match.sv
// Per-operand dependency check: compares one ID source against EX, MEM, WB and
// the retired buffer, and picks the bypass select (MEM > WB > retired).
module src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              forwarding_en,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [REG_AW-1:0] ret_dest,
  input  logic              ex_reg_write,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              ret_valid,
  output logic [1:0]        sel,
  output logic              ex_match,
  output logic              mem_match,
  output logic              wb_match,
  output logic              ret_match
);

  logic live;

  assign live      = used && (src != '0);
  assign ex_match  = live && ex_reg_write  && (src == ex_dest);
  assign mem_match = live && mem_reg_write && (src == mem_dest);
  assign wb_match  = live && wb_reg_write  && (src == wb_dest);
  assign ret_match = live && ret_valid     && (src == ret_dest);

  always_comb begin
    sel = SEL_RF;
    if (forwarding_en) begin
      if (mem_match)      sel = SEL_MEM;
      else if (wb_match)  sel = SEL_WB;
      else if (ret_match) sel = SEL_RET;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller beside the ID stage: operand selects, stall/bubble,
// memory-wait FSM with sticky timeout. Define HAZARD_PERF_EN to add 32-bit perf counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int DATA_W   = 16,
  parameter int N_SRC    = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    forwarding_en,
  input  logic [N_SRC*REG_AW-1:0] id_src,
  input  logic [N_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]       ex_dest,
  input  logic [REG_AW-1:0]       mem_dest,
  input  logic [REG_AW-1:0]       wb_dest,
  input  logic                    ex_reg_write,
  input  logic                    mem_reg_write,
  input  logic                    wb_reg_write,
  input  logic                    ex_mem_read,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    mem_access,
  input  logic                    mem_ready,
  output logic [2*N_SRC-1:0]      sel,
  output logic [DATA_W-1:0]       retired_data,
  output logic                    stall_if_id,
  output logic                    bubble_ex,
  output logic                    hold_mem,
  output logic                    mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             bubble_count,
  output logic [31:0]             wait_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  ret_entry_t       ret_q, ret_d;
  wait_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [N_SRC-1:0]   ex_m, mem_m, wb_m, ret_m;
  logic [2*N_SRC-1:0] sel_raw;
  logic               hold_raw, load_use, any_match, hazard;
  logic               unused_ret;

  assign unused_ret = ^ret_q;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    src_match #(.REG_AW(REG_AW)) u_src_match (
      .src           (id_src[gi*REG_AW +: REG_AW]),
      .used          (id_src_used[gi]),
      .forwarding_en (forwarding_en),
      .ex_dest       (ex_dest),
      .mem_dest      (mem_dest),
      .wb_dest       (wb_dest),
      .ret_dest      (ret_q.dest[REG_AW-1:0]),
      .ex_reg_write  (ex_reg_write),
      .mem_reg_write (mem_reg_write),
      .wb_reg_write  (wb_reg_write),
      .ret_valid     (ret_q.valid),
      .sel           (sel_raw[2*gi +: 2]),
      .ex_match      (ex_m[gi]),
      .mem_match     (mem_m[gi]),
      .wb_match      (wb_m[gi]),
      .ret_match     (ret_m[gi])
    );
  end

  // Without forwarding every in-flight producer is a hazard; with it only a load in EX.
  always_comb begin
    hold_raw  = mem_access && !mem_ready;
    load_use  = ex_mem_read && (|ex_m);
    any_match = |{ex_m, mem_m, wb_m, ret_m};
    hazard    = forwarding_en ? load_use : any_match;
  end

  assign sel          = rst ? '0 : sel_raw;
  assign hold_mem     = !rst && hold_raw;
  assign stall_if_id  = !rst && (hazard || hold_raw);
  assign bubble_ex    = !rst && hazard && !hold_raw;
  assign retired_data = rst ? '0 : ret_q.data[DATA_W-1:0];
  assign mem_timeout  = !rst && timeout_q;

  always_comb begin
    ret_d = ret_q;
    if (wb_reg_write && (wb_dest != '0)) begin
      ret_d.valid = 1'b1;
      ret_d.dest  = RET_AW_MAX'(wb_dest);
      ret_d.data  = RET_DW_MAX'(wb_data);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (hold_raw) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_MAX) timeout_d = 1'b1;
        if (!hold_raw) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q     <= '0;
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      ret_q     <= ret_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q  + 32'(stall_if_id);
    bubble_cnt_d = bubble_cnt_q + 32'(bubble_ex);
    wait_cnt_d   = wait_cnt_q   + 32'(hold_mem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign stall_cycles = rst ? '0 : stall_cnt_q;
  assign bubble_count = rst ? '0 : bubble_cnt_q;
  assign wait_cycles  = rst ? '0 : wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: vector table, directed multi-cycle
// sequences, then random stimulus against a behavioural reference model.
module tb_hazard_forward_unit;

  localparam int REG_AW   = 3;
  localparam int DATA_W   = 16;
  localparam int N_SRC    = 2;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    forwarding_en;
  logic [N_SRC*REG_AW-1:0] id_src;
  logic [N_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]       ex_dest, mem_dest, wb_dest;
  logic                    ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
  logic [DATA_W-1:0]       wb_data;
  logic                    mem_access, mem_ready;
  logic [2*N_SRC-1:0]      sel;
  logic [DATA_W-1:0]       retired_data;
  logic                    stall_if_id, bubble_ex, hold_mem, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]             stall_cycles, bubble_count, wait_cycles;
`endif

  hazard_forward_unit #(
    .REG_AW(REG_AW), .DATA_W(DATA_W), .N_SRC(N_SRC), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .forwarding_en(forwarding_en),
    .id_src(id_src), .id_src_used(id_src_used),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .wb_data(wb_data),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .sel(sel), .retired_data(retired_data),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .hold_mem(hold_mem),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .bubble_count(bubble_count), .wait_cycles(wait_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: retired buffer, wait tracking, sticky timeout.
  logic              m_ret_valid;
  logic [REG_AW-1:0] m_ret_dest;
  logic [DATA_W-1:0] m_ret_data;
  bit                m_waiting;
  int                m_wait_len;
  bit                m_timeout;

  always @(posedge clk) begin
    if (rst) begin
      m_ret_valid <= 1'b0;
      m_ret_dest  <= '0;
      m_ret_data  <= '0;
      m_waiting   <= 1'b0;
      m_wait_len  <= 0;
      m_timeout   <= 1'b0;
    end else begin
      if (wb_reg_write && wb_dest != 0) begin
        m_ret_valid <= 1'b1;
        m_ret_dest  <= wb_dest;
        m_ret_data  <= wb_data;
      end
      if (m_waiting) begin
        m_wait_len <= m_wait_len + 1;
        if (m_wait_len + 1 >= MAX_WAIT) m_timeout <= 1'b1;
      end else begin
        m_wait_len <= 0;
      end
      m_waiting <= mem_access && !mem_ready;
    end
  end

  task automatic model_outputs(output logic [2*N_SRC-1:0] e_sel, output logic e_stall,
                               output logic e_bub, output logic e_hold);
    logic any_hit, lu, haz;
    logic [REG_AW-1:0] s;
    logic live, hex, hmem, hwb, hret;
    any_hit = 1'b0;
    lu      = 1'b0;
    e_sel   = '0;
    e_hold  = mem_access && !mem_ready;
    for (int i = 0; i < N_SRC; i++) begin
      s    = id_src[i*REG_AW +: REG_AW];
      live = id_src_used[i] && (s != 0);
      hex  = live && ex_reg_write  && (s == ex_dest);
      hmem = live && mem_reg_write && (s == mem_dest);
      hwb  = live && wb_reg_write  && (s == wb_dest);
      hret = live && m_ret_valid   && (s == m_ret_dest);
      any_hit = any_hit | hex | hmem | hwb | hret;
      lu      = lu | (hex && ex_mem_read);
      if (forwarding_en)
        e_sel[2*i +: 2] = hmem ? 2'd1 : hwb ? 2'd2 : hret ? 2'd3 : 2'd0;
    end
    haz     = forwarding_en ? lu : any_hit;
    e_stall = haz || e_hold;
    e_bub   = haz && !e_hold;
    if (rst) begin
      e_sel = '0; e_stall = 1'b0; e_bub = 1'b0; e_hold = 1'b0;
    end
  endtask

  task automatic zero_inputs();
    forwarding_en = 1'b1; id_src = '0; id_src_used = '0;
    ex_dest = '0; mem_dest = '0; wb_dest = '0;
    ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0; ex_mem_read = 1'b0;
    wb_data = '0; mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       fwd;
    logic [2:0] s0, s1;
    logic [1:0] used;
    logic [2:0] exd, memd, wbd;
    logic       exw, memw, wbw, exrd, acc, rdy;
    logic [3:0] e_sel;
    logic       e_stall, e_bub, e_hold;
    string      name;
  } vec_t;

  vec_t tbl[13];

  logic [2*N_SRC-1:0] m_sel;
  logic m_stall, m_bub, m_hold;
  logic [31:0] rnd;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         fwd s0 s1 used exd memd wbd exw memw wbw exrd acc rdy sel stall bub hold
    tbl[0]  = '{1, 3, 0, 3, 0, 3, 3, 0, 1, 1, 0, 0, 0, 4'b0001, 0, 0, 0, "mem_over_wb"};
    tbl[1]  = '{1, 3, 0, 3, 0, 3, 3, 0, 0, 1, 0, 0, 0, 4'b0010, 0, 0, 0, "wb_when_mem_off"};
    tbl[2]  = '{1, 2, 0, 3, 2, 0, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 1, 1, 0, "load_use"};
    tbl[3]  = '{1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, "src_zero"};
    tbl[4]  = '{1, 2, 0, 2, 2, 0, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, "unused_src"};
    tbl[5]  = '{0, 0, 4, 3, 0, 4, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, "interlock_mem"};
    tbl[6]  = '{0, 1, 2, 3, 5, 6, 7, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, "interlock_clear"};
    tbl[7]  = '{1, 2, 0, 3, 2, 0, 0, 1, 0, 0, 1, 1, 0, 4'b0000, 1, 0, 1, "hold_over_bubble"};
    tbl[8]  = '{1, 2, 0, 3, 2, 0, 0, 1, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, "ready_no_hold"};
    tbl[9]  = '{1, 6, 0, 3, 6, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "ex_alu_no_stall"};
    tbl[10] = '{1, 5, 6, 3, 0, 5, 6, 0, 1, 1, 0, 0, 0, 4'b1001, 0, 0, 0, "two_operands"};
    tbl[11] = '{1, 0, 2, 3, 2, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, "ex_no_write"};
    tbl[12] = '{0, 0, 3, 3, 0, 0, 3, 0, 0, 1, 0, 0, 0, 4'b0000, 1, 1, 0, "interlock_wb"};

    rst = 1'b1;
    zero_inputs();
    next_cycle();
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_stall", 32'(stall_if_id), 32'd0);
    chk("reset_hold", 32'(hold_mem), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    rst = 1'b0;

    // Table-driven single-cycle vectors, each from a clean reset.
    for (int v = 0; v < 13; v++) begin
      do_reset();
      forwarding_en = tbl[v].fwd;
      id_src        = {tbl[v].s1, tbl[v].s0};
      id_src_used   = tbl[v].used;
      ex_dest = tbl[v].exd; mem_dest = tbl[v].memd; wb_dest = tbl[v].wbd;
      ex_reg_write = tbl[v].exw; mem_reg_write = tbl[v].memw; wb_reg_write = tbl[v].wbw;
      ex_mem_read = tbl[v].exrd; mem_access = tbl[v].acc; mem_ready = tbl[v].rdy;
      @(negedge clk);
      chk({tbl[v].name, "_sel"},   32'(sel),         32'(tbl[v].e_sel));
      chk({tbl[v].name, "_stall"}, 32'(stall_if_id), 32'(tbl[v].e_stall));
      chk({tbl[v].name, "_bub"},   32'(bubble_ex),   32'(tbl[v].e_bub));
      chk({tbl[v].name, "_hold"},  32'(hold_mem),    32'(tbl[v].e_hold));
      $display("[TB] vec %-18s sel=%b stall=%b bub=%b hold=%b", tbl[v].name, sel,
               stall_if_id, bubble_ex, hold_mem);
    end

    // Retired-buffer path, then same-cycle WB write overriding the buffer.
    do_reset();
    id_src_used = 2'b11;
    wb_reg_write = 1'b1; wb_dest = 3'd5; wb_data = 16'hBEEF;
    next_cycle();
    wb_reg_write = 1'b0; id_src = {3'd5, 3'd0};
    @(negedge clk);
    chk("ret_sel", 32'(sel), 32'b1100);
    chk("ret_data", 32'(retired_data), 32'hBEEF);
    $display("[TB] retired sel=%b data=%h", sel, retired_data);
    next_cycle();
    wb_reg_write = 1'b1; wb_dest = 3'd5; wb_data = 16'h1234;
    @(negedge clk);
    chk("wb_over_ret_sel", 32'(sel), 32'b1000);
    next_cycle();
    wb_reg_write = 1'b0;
    @(negedge clk);
    chk("ret_update_data", 32'(retired_data), 32'h1234);
    chk("ret_update_sel", 32'(sel), 32'b1100);
    $display("[TB] retired-update sel=%b data=%h", sel, retired_data);

    // Load-use costs exactly one bubble.
    do_reset();
    id_src_used = 2'b11; id_src = {3'd0, 3'd2};
    ex_dest = 3'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    @(negedge clk);
    chk("lu_stall", 32'(stall_if_id), 32'd1);
    chk("lu_bubble", 32'(bubble_ex), 32'd1);
    next_cycle();
    mem_dest = 3'd2; mem_reg_write = 1'b1; ex_dest = 3'd4; ex_mem_read = 1'b0;
    @(negedge clk);
    chk("lu_next_stall", 32'(stall_if_id), 32'd0);
    chk("lu_next_bubble", 32'(bubble_ex), 32'd0);
    chk("lu_next_sel", 32'(sel), 32'b0001);
    $display("[TB] load-use follow-up sel=%b stall=%b", sel, stall_if_id);

    // Memory wait: 16 cycles without ready raises the sticky timeout.
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("wait%0d_hold", k), 32'(hold_mem), 32'd1);
      chk($sformatf("wait%0d_bub", k), 32'(bubble_ex), 32'd0);
      chk($sformatf("wait%0d_stall", k), 32'(stall_if_id), 32'd1);
      chk($sformatf("wait%0d_timeout", k), 32'(mem_timeout), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("timeout_rise", 32'(mem_timeout), 32'd1);
    $display("[TB] wait after 16 edges hold=%b timeout=%b", hold_mem, mem_timeout);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("timeout_sticky", 32'(mem_timeout), 32'd1);
      chk("ready_hold", 32'(hold_mem), 32'd0);
    end

    // Reset in the middle of a wait, with hazards that would otherwise show.
    do_reset();
    wb_reg_write = 1'b1; wb_dest = 3'd3; wb_data = 16'hA5A5;
    next_cycle();
    wb_reg_write = 1'b0; mem_access = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) next_cycle();
    rst = 1'b1;
    id_src_used = 2'b11; id_src = {3'd3, 3'd2};
    ex_dest = 3'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_stall", 32'(stall_if_id), 32'd0);
    chk("rst_bub", 32'(bubble_ex), 32'd0);
    chk("rst_hold", 32'(hold_mem), 32'd0);
    chk("rst_retdata", 32'(retired_data), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_hold", 32'(hold_mem), 32'd1);
    chk("post_rst_bub", 32'(bubble_ex), 32'd0);
    chk("post_rst_ret_invalid", 32'(sel), 32'd0);
    chk("post_rst_retdata", 32'(retired_data), 32'd0);
    for (int k = 1; k <= 15; k++) next_cycle();
    @(negedge clk);
    chk("post_rst_cnt_cleared", 32'(mem_timeout), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post_rst_timeout", 32'(mem_timeout), 32'd1);
    $display("[TB] reset-mid-wait hold=%b timeout=%b", hold_mem, mem_timeout);

    // Random stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      rst           = ($urandom_range(0, 59) == 0);
      forwarding_en = ($urandom_range(0, 3) != 0);
      id_src        = rnd[5:0];
      id_src_used   = rnd[7:6];
      ex_dest       = rnd[10:8];
      mem_dest      = rnd[13:11];
      wb_dest       = rnd[16:14];
      ex_reg_write  = rnd[17];
      mem_reg_write = rnd[18];
      wb_reg_write  = rnd[19];
      ex_mem_read   = rnd[20];
      wb_data       = 16'($urandom);
      if (((i / 50) % 2) == 1) begin
        mem_access = 1'b1;
        mem_ready  = ($urandom_range(0, 24) == 0);
      end else begin
        mem_access = rnd[21];
        mem_ready  = rnd[22];
      end
      @(negedge clk);
      model_outputs(m_sel, m_stall, m_bub, m_hold);
      chk($sformatf("rnd%0d_sel", i), 32'(sel), 32'(m_sel));
      chk($sformatf("rnd%0d_stall", i), 32'(stall_if_id), 32'(m_stall));
      chk($sformatf("rnd%0d_bub", i), 32'(bubble_ex), 32'(m_bub));
      chk($sformatf("rnd%0d_hold", i), 32'(hold_mem), 32'(m_hold));
      chk($sformatf("rnd%0d_retdata", i), 32'(retired_data), rst ? 32'd0 : 32'(m_ret_data));
      chk($sformatf("rnd%0d_timeout", i), 32'(mem_timeout), rst ? 32'd0 : 32'(m_timeout));
      $display("[TB] rnd %0d rst=%b sel=%b stall=%b bub=%b hold=%b to=%b", i, rst, sel,
               stall_if_id, bubble_ex, hold_mem, mem_timeout);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It is the successor to the 2-source MEM/WB forwarding mux-select logic. It adds:
- N source ports with configurable register-address width;
- a third bypass path from a one-entry retired-write buffer;
- load-use bubble insertion;
- a full-interlock mode when forwarding is disabled;
- a memory-wait state machine with a timeout flag.

It sits beside the ID stage and drives the EX operand muxes and the pipeline-register enables.

## Interface
Parameters:
- REG_AW, 3, register address width; address 0 is hardwired zero
- DATA_W, 16, datapath width of the retired buffer
- N_SRC, 2, number of ID-stage source operands
- MAX_WAIT, 15, memory-wait cycles before timeout flag

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- forwarding_en  in  1  1 = bypass mode, 0 = full interlock mode
- id_src  in  N_SRC*REG_AW  ID source addresses; operand i is bits [i*REG_AW +: REG_AW]
- id_src_used  in  N_SRC  operand i is actually read
- ex_dest, mem_dest, wb_dest  in  REG_AW  destination address per stage
- ex_reg_write, mem_reg_write, wb_reg_write  in  1  stage will write its destination
- ex_mem_read  in  1  EX instruction is a load
- wb_data  in  DATA_W  value written back this cycle
- mem_access, mem_ready  in  1  MEM-stage memory request and its completion
- sel  out  2*N_SRC  per-operand mux select: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 retired buffer
- retired_data  out  DATA_W  retired-buffer value for sel = 3
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- hold_mem  out  1  hold ID/EX and EX/MEM; inject a NOP into MEM/WB
- mem_timeout  out  1  sticky wait-timeout flag

## Operation
- Match definition: source i matches stage S when all hold:
  - id_src_used[i] = 1;
  - src != 0;
  - src == S_dest;
  - S_reg_write = 1.
- Bypass mode (forwarding_en = 1), sel priority per operand:
  - MEM match → 1;
  - else WB match → 2;
  - else retired-buffer match (buffer valid) → 3;
  - else 0.
- Load-use hazard: any used source matches EX with ex_mem_read = 1. Response: stall_if_id = 1 and bubble_ex = 1 for that cycle.
- Interlock mode (forwarding_en = 0):
  - every sel = 0;
  - any match on EX, MEM, WB or the retired buffer → stall_if_id = 1 and bubble_ex = 1.
- Retired buffer: {valid, dest, data}. It captures wb_dest and wb_data each cycle in which wb_reg_write = 1 and wb_dest != 0; otherwise it holds its contents.
- Memory wait:
  - hold_mem = mem_access & ~mem_ready, combinational;
  - whenever hold_mem = 1, stall_if_id = 1 and bubble_ex = 0 (EX is frozen; the hold overrides a load-use bubble).
- FSM states RUN and MEM_WAIT:
  - RUN → MEM_WAIT when hold_mem = 1;
  - MEM_WAIT → RUN when mem_ready = 1 or mem_access = 0;
  - wait counter is cleared in RUN and increments in MEM_WAIT, saturating at MAX_WAIT; its width is $clog2(MAX_WAIT+1);
  - mem_timeout is set on the cycle the counter reaches MAX_WAIT and is cleared only by rst.
- sel values stay live during stalls; the consumer ignores them while frozen.

## Timing
- sel, stall_if_id, bubble_ex and hold_mem are combinational from the current inputs plus registered state, with zero-cycle latency.
- Retired buffer, FSM, counter and mem_timeout update on the rising clk edge.
- A WB write at cycle t is visible with sel = 3 at cycle t+1, provided no younger stage matches.
- Load-use costs exactly 1 bubble. The next cycle the load is in MEM, so no match is produced from EX.
- Reset: while rst = 1, all outputs are 0. Registered state at the first cycle after reset:
  - FSM = RUN;
  - buffer valid = 0, dest = 0, data = 0;
  - counter = 0;
  - mem_timeout = 0;
  - perf counters = 0.
- rst during MEM_WAIT returns the FSM to RUN on the next edge and clears the counter, but does not clear hold_mem if mem_access is still low-ready after reset deasserts.
- Simultaneous events: if a WB write and a retired-buffer match to the same address occur in one cycle, sel = 2 (newer data wins).

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cycles, bubble_count and wait_cycles, each 32-bit.
  - They increment on stall_if_id, bubble_ex and hold_mem cycles respectively.
  - They wrap modulo 2^32 and clear on rst.
- Not defined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - the sel encodings as constants: SEL_RF = 0, SEL_MEM = 1, SEL_WB = 2, SEL_RET = 3;
  - the FSM state enum;
  - the retired-entry struct.
- One sub-module, src_match, is instantiated N_SRC times. It takes one source plus the stage info and produces that operand's sel and match flags. The top level ORs the flags and holds the FSM, buffer and counters.

## Test plan
- Bypass priority: src0 = 3, mem_dest = 3, wb_dest = 3, both reg_write = 1 → sel[1:0] = 1. Drop mem_reg_write → 2.
- Retired path: WB writes r5 = 0xBEEF at t. At t+1, src1 = 5 with no other match → sel[3:2] = 3, retired_data = 0xBEEF.
- Load-use: ex_mem_read = 1, ex_dest = 2, src0 = 2 → stall_if_id = 1, bubble_ex = 1 for exactly one cycle. src = 0 → no stall.
- Interlock: forwarding_en = 0, mem_dest matches src1 → sel = 0, stall_if_id = 1, bubble_ex = 1.
- Memory wait: mem_access = 1, mem_ready = 0 for 16 cycles with MAX_WAIT = 15 → hold_mem = 1 throughout, bubble_ex = 0, mem_timeout rises at the 16th edge. Then mem_ready = 1 → RUN, mem_timeout stays 1 until rst.
- Reset mid-wait: assert rst in MEM_WAIT → next cycle FSM = RUN, counter = 0, buffer invalid, all outputs 0 during rst.
